// File: rtl/ras_if.sv
// Strobe/data bundle between the return-address-stack controller and its storage.
// master = controller side (drives strobes), slave = ras_stack side.
interface ras_if #(
    parameter int XLEN  = 32,
    parameter int PTR_W = 3
);
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  pctoras;
    logic             ckpt_save;
    logic             ckpt_restore;
    logic [XLEN-1:0]  pcfromras;
    logic             empty;
    logic             full;
    logic [PTR_W:0]   count;
    logic             ovf;
    logic             unf;

    modport master (
        output push, pop, pctoras, ckpt_save, ckpt_restore,
        input  pcfromras, empty, full, count, ovf, unf
    );

    modport slave (
        input  push, pop, pctoras, ckpt_save, ckpt_restore,
        output pcfromras, empty, full, count, ovf, unf
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack with combinational top-of-stack read.
// Define RAS_CKPT_EN to build the single-level pointer checkpoint/restore.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int XLEN  = 32
) (
    input logic  clk,
    input logic  reset,
    ras_if.slave bus
);
    localparam logic [PTR_W-1:0] TOS_RST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [PTR_W:0]   cnt;
    logic             ovf_q;
    logic             unf_q;
    logic [PTR_W-1:0] tos_inc;
    logic             is_empty;
    logic             is_full;

    // Natural PTR_W-bit wrap gives the modulo-DEPTH pointer arithmetic.
    assign tos_inc  = tos + PTR_W'(1);
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

`ifdef RAS_CKPT_EN
    logic [PTR_W-1:0] s_tos;
    logic [PTR_W:0]   s_cnt;

    // A save coinciding with a restore is dropped so the snapshot survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_tos <= TOS_RST;
            s_cnt <= '0;
        end else if (bus.ckpt_save && !bus.ckpt_restore) begin
            s_tos <= tos;
            s_cnt <= cnt;
        end
    end
`else
    logic unused_ckpt;
    assign unused_ckpt = bus.ckpt_save ^ bus.ckpt_restore;
`endif

    // NOTE: all state here updates with <= so every branch sees pre-edge tos/cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            tos   <= TOS_RST;
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            // NOTE: the array is cleared on reset because it is small and reset contents are defined.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifdef RAS_CKPT_EN
            if (bus.ckpt_restore) begin
                tos <= s_tos;
                cnt <= s_cnt;
            end else
`endif
            if (bus.push && bus.pop && !is_empty) begin
                // Return-then-call: replace the top in place.
                mem[tos] <= bus.pctoras;
            end else if (bus.push) begin
                tos          <= tos_inc;
                mem[tos_inc] <= bus.pctoras;
                if (is_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (bus.pop) begin
                if (is_empty) begin
                    unf_q <= 1'b1;
                end else begin
                    tos <= tos - PTR_W'(1);
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign bus.pcfromras = is_empty ? '1 : mem[tos];
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.count     = cnt;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: directed scenarios then random strobes against a
// queue/array reference model. Honours RAS_CKPT_EN the same way the design does.
module tb_ras_stack;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int XLEN  = 32;
`ifdef RAS_CKPT_EN
    localparam bit CKPT = 1'b1;
`else
    localparam bit CKPT = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    ras_if #(.XLEN(XLEN), .PTR_W(PTR_W)) bus ();

    ras_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model: unbounded logical top index mapped onto DEPTH slots.
    logic [31:0] m_arr [DEPTH];
    int          m_top, m_cnt, m_stop, m_scnt;
    logic        m_ovf, m_unf;

    function automatic int slot(input int t);
        return ((t % DEPTH) + DEPTH) % DEPTH;
    endfunction

    function automatic void model_reset();
        foreach (m_arr[i]) m_arr[i] = 32'h0;
        m_top  = DEPTH - 1;
        m_cnt  = 0;
        m_stop = DEPTH - 1;
        m_scnt = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    function automatic void model_step(input logic p, input logic q, input logic [31:0] a,
                                       input logic sv, input logic rs, input logic rst);
        if (rst) begin
            model_reset();
            return;
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (CKPT && rs) begin
            m_top = m_stop;
            m_cnt = m_scnt;
            return;
        end
        if (CKPT && sv) begin
            m_stop = m_top;
            m_scnt = m_cnt;
        end
        if (p && q && m_cnt > 0) begin
            m_arr[slot(m_top)] = a;
        end else if (p) begin
            m_top++;
            m_arr[slot(m_top)] = a;
            if (m_cnt == DEPTH) m_ovf = 1'b1;
            else m_cnt++;
        end else if (q) begin
            if (m_cnt > 0) begin
                m_top--;
                m_cnt--;
            end else begin
                m_unf = 1'b1;
            end
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.pc    = (m_cnt == 0) ? 32'hFFFF_FFFF : m_arr[slot(m_top)];
        e.count = 4'(m_cnt);
        e.empty = (m_cnt == 0);
        e.full  = (m_cnt == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: record what the DUT should show now, then drive the next strobes.
    task automatic step(input logic p, input logic q, input logic [31:0] a,
                        input logic sv = 1'b0, input logic rs = 1'b0, input logic rst = 1'b0);
        @(posedge clk);
        #1;
        exp_q.push_back(model_outputs());
        reset            = rst;
        bus.push         = p;
        bus.pop          = q;
        bus.pctoras      = a;
        bus.ckpt_save    = sv;
        bus.ckpt_restore = rs;
        model_step(p, q, a, sv, rs, rst);
    endtask

    // Monitor: every mid-cycle sample is compared with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pcfromras", bus.pcfromras, e.pc);
                check("count", 32'(bus.count), 32'(e.count));
                check("empty", 32'(bus.empty), 32'(e.empty));
                check("full", 32'(bus.full), 32'(e.full));
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
                check("unf", 32'(bus.unf), 32'(e.unf));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.pctoras      = '0;
        bus.ckpt_save    = 1'b0;
        bus.ckpt_restore = 1'b0;
        model_reset();

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0);
        // Basic push/pop ordering.
        step(1, 0, 32'h100);
        step(1, 0, 32'h200);
        step(1, 0, 32'h300);
        step(0, 0, 0);
        repeat (3) step(0, 1, 0);
        step(0, 0, 0);
        // Overflow: nine pushes into eight entries, then drain.
        for (int i = 0; i < 9; i++) step(1, 0, 32'h1000 + 32'(i));
        step(0, 0, 0);
        repeat (8) step(0, 1, 0);
        // Underflow pulse and hold.
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        // Simultaneous push and pop, non-empty then empty.
        step(1, 0, 32'h40);
        step(1, 1, 32'h80);
        step(0, 0, 0);
        step(0, 1, 0);
        step(1, 1, 32'h44);
        step(0, 0, 0);
        step(0, 1, 0);
        // Checkpoint save/restore and restore-over-push.
        step(1, 0, 32'hA0);
        step(1, 0, 32'hB0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 0, 32'hC0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 32'hD0, 0, 1);
        step(1, 0, 32'hE0, 1, 1);
        step(0, 0, 0);
        // Reset together with a push at count 5.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 32'h500 + 32'(i));
        step(1, 0, 32'h5FF, 0, 0, 1);
        step(0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            logic p, q, sv, rs, rst;
            r   = int'($urandom_range(0, 99));
            p   = (r < 50);
            q   = (r >= 35 && r < 85);
            sv  = ($urandom_range(0, 99) < 8);
            rs  = ($urandom_range(0, 99) < 6);
            rst = ($urandom_range(0, 199) == 0);
            step(p, q, $urandom, sv, rs, rst);
        end
        step(0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
